// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader that holds the core in reset until the image is written
// Optional trailing checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int Data_Width = 32,
    parameter int Depth      = 100,
    parameter int Len_Width  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [Len_Width-1:0]  Len,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWE,
    output logic [Data_Width-1:0] MemAddr,
    output logic [Data_Width-1:0] MemWD,
    output logic                  CoreRST,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

    state_t               state, state_n;
    logic [1:0]           byte_idx;
    logic [Len_Width-1:0] word_cnt;
    logic [Len_Width-1:0] len_q;
    logic                 byte_fire;
    logic                 last_byte;
    logic                 len_ok;
    logic                 start_ok;
    logic                 last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [Data_Width-1:0] sum_q;
    logic [Data_Width-1:0] chk_q;
    logic                  chk_match;

    assign chk_match = ({ByteIn, chk_q[23:0]} == sum_q);
`endif

    // ByteReady is a registered copy of "state is COLLECT/CHECK", so the handshake is exact
    assign byte_fire = ByteValid && ByteReady;
    assign last_byte = byte_fire && (byte_idx == 2'd3);
    assign len_ok    = (Len != '0) && (Len <= Len_Width'(Depth));
    assign start_ok  = Start && ((state == S_IDLE) || (state == S_DONE));
    assign last_word = ((word_cnt + Len_Width'(1)) == len_q);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (Start && len_ok) state_n = S_COLLECT;
            end
            S_COLLECT: begin
                if (last_byte) state_n = S_WRITE;
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_n = last_word ? S_CHECK : S_COLLECT;
`else
                state_n = last_word ? S_DONE : S_COLLECT;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (last_byte) state_n = chk_match ? S_DONE : S_IDLE;
            end
`endif
            S_DONE: begin
                if (Start) state_n = len_ok ? S_COLLECT : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            byte_idx  <= '0;
            word_cnt  <= '0;
            len_q     <= '0;
            ByteReady <= 1'b0;
            MemWE     <= 1'b0;
            MemAddr   <= '0;
            MemWD     <= '0;
            CoreRST   <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            chk_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            ByteReady <= (state_n == S_COLLECT)
`ifdef IMEM_LOADER_CHECKSUM_EN
                         || (state_n == S_CHECK)
`endif
                         ;
            MemWE     <= (state_n == S_WRITE);
            Busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
            Done      <= (state_n == S_DONE);
            CoreRST   <= (state_n == S_DONE);

            if (start_ok) begin
                Error <= !len_ok;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            else if ((state == S_CHECK) && last_byte && !chk_match) begin
                Error <= 1'b1;
            end
`endif

            if (start_ok && len_ok) begin
                byte_idx <= '0;
                word_cnt <= '0;
                MemAddr  <= '0;
                len_q    <= Len;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q    <= '0;
`endif
            end

            if (byte_fire) begin
                byte_idx <= byte_idx + 2'd1;
                if (state == S_COLLECT) MemWD[{byte_idx, 3'b000} +: 8] <= ByteIn;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (state == S_CHECK) chk_q[{byte_idx, 3'b000} +: 8] <= ByteIn;
`endif
            end

            // Address and count advance on leaving WRITE so they stay stable during the pulse
            if (state == S_WRITE) begin
                MemAddr  <= MemAddr + Data_Width'(4);
                word_cnt <= word_cnt + Len_Width'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q    <= sum_q + MemWD;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-level reference model
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Len = '0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady, MemWE, CoreRST, Busy, Done, Error;
    logic [31:0] MemAddr, MemWD;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] got_q[$];
    int          exp_n = 0;
    bit          last_we = 1'b0;

    imem_loader dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Len(Len),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
        .CoreRST(CoreRST), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (last_we && exp_n > 0 && got_q.size() == exp_n)
            check("done_one_cycle_after_last_write", 32'({Done, CoreRST}), 32'd3);
`endif
        if (MemWE) begin
            check("byte_ready_low_in_write", 32'(ByteReady), 32'd0);
            got_q.push_back({MemAddr, MemWD});
        end
        last_we = MemWE;
    end

    task automatic start_pulse(input logic [15:0] l);
        @(negedge CLK);
        Start = 1'b1;
        Len   = l;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        ByteIn    = b;
        ByteValid = 1'b1;
        t = 0;
        while (!ByteReady && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        ByteValid = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] bytes[$], input int i);
        return 32'(bytes[4*i]) + (32'(bytes[4*i+1]) << 8) +
               (32'(bytes[4*i+2]) << 16) + (32'(bytes[4*i+3]) << 24);
    endfunction

    // Drives the payload (plus checksum when enabled) after Start and checks the session result.
    task automatic feed(input logic [15:0] len, input logic [7:0] bytes[$], input int gap_max,
                        input int start_at, input bit corrupt);
        logic [7:0]  stream[$];
        logic [31:0] sum;
        int          t;
        bit          exp_err;
        stream  = bytes;
        sum     = 32'd0;
        exp_err = 1'b0;
        exp_n   = int'(len);
        for (int i = 0; i < int'(len); i++) sum = sum + model_word(bytes, i);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (corrupt) sum = sum ^ 32'd1;
        exp_err = corrupt;
        for (int i = 0; i < 4; i++) stream.push_back(8'((sum >> (8*i)) & 32'hFF));
`endif
        for (int k = 0; k < stream.size(); k++) begin
            if (k == start_at) begin
                @(negedge CLK);
                Start = 1'b1;
                Len   = 16'd7;
                @(negedge CLK);
                Start = 1'b0;
                Len   = len;
            end
            send_byte(stream[k], int'($urandom_range(gap_max, 0)));
        end
        t = 0;
        while (!(Done || Error) && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check("session_end_timeout", 32'(t < 40), 32'd1);
        check("write_count", 32'(got_q.size()), 32'(len));
        for (int i = 0; i < int'(len) && i < got_q.size(); i++) begin
            check("write_addr", got_q[i][63:32], 32'(4*i));
            check("write_data", got_q[i][31:0], model_word(bytes, i));
        end
        check("done_flag", 32'(Done), 32'(!exp_err));
        check("error_flag", 32'(Error), 32'(exp_err));
        check("core_rst", 32'(CoreRST), 32'(!exp_err));
        check("busy_after", 32'(Busy), 32'd0);
    endtask

    logic [7:0] tp_bytes[$];
    logic [7:0] rnd[$];
    logic [15:0] rl;

    initial begin
        tp_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};

        repeat (3) @(negedge CLK);
        check("rst_outputs", 32'({ByteReady, MemWE, CoreRST, Busy, Done, Error}), 32'd0);
        check("rst_addr", MemAddr, 32'd0);
        check("rst_wd", MemWD, 32'd0);
        RST = 1'b1;

        // Invalid lengths from IDLE
        start_pulse(16'd0);
        check("len0_error", 32'(Error), 32'd1);
        check("len0_idle", 32'({Busy, ByteReady, CoreRST, Done}), 32'd0);
        start_pulse(16'd101);
        repeat (3) @(negedge CLK);
        check("len101_error", 32'(Error), 32'd1);
        check("len101_idle", 32'({Busy, ByteReady, CoreRST, Done}), 32'd0);
        check("len_err_no_write", 32'(got_q.size()), 32'd0);

        // Test-plan image, streaming back to back
        got_q.delete();
        start_pulse(16'd2);
        check("start_to_ready", 32'({ByteReady, Busy, Error}), 32'd6);
        feed(16'd2, tp_bytes, 0, -1, 1'b0);
        check("tp_word0", got_q[0][31:0], 32'h00500513);
        check("tp_word1", got_q[1][31:0], 32'h00A00593);
        check("tp_addr1", got_q[1][63:32], 32'h4);

        // Start in DONE restarts immediately at address 0
        got_q.delete();
        start_pulse(16'd2);
        check("done_restart_core_rst", 32'(CoreRST), 32'd0);
        check("done_restart_busy", 32'({Busy, Done}), 32'd2);
        feed(16'd2, tp_bytes, 0, -1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        got_q.delete();
        start_pulse(16'd2);
        feed(16'd2, tp_bytes, 0, -1, 1'b1);
`endif

        // Same image with a 3-cycle bubble before every byte
        got_q.delete();
        start_pulse(16'd2);
        for (int k = 0; k < 8; k++) rnd.push_back(tp_bytes[k]);
        feed(16'd2, rnd, 0, -1, 1'b0);
        got_q.delete();
        start_pulse(16'd2);
        exp_n = 2;
        for (int k = 0; k < 8; k++) send_byte(tp_bytes[k], 3);
        repeat (3) @(negedge CLK);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("gap_done", 32'(Done), 32'd1);
`endif
        check("gap_count", 32'(got_q.size()), 32'd2);
        check("gap_word1", got_q[1][31:0], 32'h00A00593);

        // Start mid-COLLECT is ignored
        got_q.delete();
        start_pulse(16'd2);
        feed(16'd2, tp_bytes, 1, 2, 1'b0);

        // Reset after 6 bytes discards the partial word
        got_q.delete();
        start_pulse(16'd2);
        exp_n = 2;
        for (int k = 0; k < 6; k++) send_byte(tp_bytes[k], 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_core", 32'({CoreRST, Busy, ByteReady, MemWE}), 32'd0);
        check("async_rst_wd", MemWD, 32'd0);
        check("writes_before_rst", 32'(got_q.size()), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        got_q.delete();
        start_pulse(16'd2);
        feed(16'd2, tp_bytes, 1, -1, 1'b0);

        // Maximum length boundary
        got_q.delete();
        rnd.delete();
        for (int k = 0; k < 400; k++) rnd.push_back(8'($urandom));
        start_pulse(16'd100);
        feed(16'd100, rnd, 0, -1, 1'b0);

        // Randomized sessions
        for (int it = 0; it < 6; it++) begin
            rl = 16'($urandom_range(6, 1));
            rnd.delete();
            for (int k = 0; k < 4*int'(rl); k++) rnd.push_back(8'($urandom));
            got_q.delete();
            start_pulse(rl);
            feed(rl, rnd, 3, -1, (it % 3) == 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
